// File: rtl/cve2_load_store_resp.sv
// Load/store response tracker: one outstanding access, merges the two halves
// of a misaligned access and formats load data for register-file writeback.
module cve2_load_store_resp (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  type_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  addr_offset_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        busy_o,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o
);

  // Handshake: req_i is taken only while IDLE (busy_o=0); each data_rvalid_i
  // outside IDLE consumes exactly one memory response, and completion is a
  // single-cycle lsu_resp_valid_o pulse one cycle after the final response.
  localparam logic [1:0] IDLE            = 2'd0;
  localparam logic [1:0] WAIT_SINGLE     = 2'd1;
  localparam logic [1:0] WAIT_MIS_FIRST  = 2'd2;
  localparam logic [1:0] WAIT_MIS_SECOND = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  type_q, type_d;
  logic        sign_ext_q, sign_ext_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        rf_we_q, rf_we_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        split_req;
  logic        complete;
  logic        final_err;
  logic [31:0] shifted;
  logic [15:0] half_data;
  logic [31:0] fmt_data;

  assign split_req = ((type_i == 2'b00 || type_i == 2'b11) && addr_offset_i != 2'd0) ||
                     (type_i == 2'b01 && addr_offset_i == 2'd3);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    type_d     = type_q;
    sign_ext_d = sign_ext_q;
    offset_d   = offset_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    complete   = 1'b0;
    final_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d       = we_i;
          type_d     = type_i;
          sign_ext_d = sign_ext_i;
          offset_d   = addr_offset_i;
          err_d      = 1'b0;
          state_d    = split_req ? WAIT_MIS_FIRST : WAIT_SINGLE;
        end
      end
      WAIT_SINGLE: begin
        if (data_rvalid_i) begin
          state_d   = IDLE;
          complete  = 1'b1;
          final_err = data_err_i;
        end
      end
      WAIT_MIS_FIRST: begin
        // A first-half error is remembered, not acted on, until the pair is done.
        if (data_rvalid_i) begin
          rdata_d = data_rdata_i;
          err_d   = data_err_i;
          state_d = WAIT_MIS_SECOND;
        end
      end
      WAIT_MIS_SECOND: begin
        if (data_rvalid_i) begin
          state_d   = IDLE;
          complete  = 1'b1;
          final_err = err_q | data_err_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data formatting uses the live response as the upper part and rdata_q as the lower part.
  always_comb begin
    shifted   = data_rdata_i >> {offset_q, 3'b000};
    half_data = (offset_q == 2'd3) ? {data_rdata_i[7:0], rdata_q[31:24]} : shifted[15:0];
    fmt_data  = data_rdata_i;
    case (type_q)
      2'b01: fmt_data = {{16{sign_ext_q & half_data[15]}}, half_data};
      2'b10: fmt_data = {{24{sign_ext_q & shifted[7]}}, shifted[7:0]};
      default: begin
        case (offset_q)
          2'd1:    fmt_data = {data_rdata_i[7:0],  rdata_q[31:8]};
          2'd2:    fmt_data = {data_rdata_i[15:0], rdata_q[31:16]};
          2'd3:    fmt_data = {data_rdata_i[23:0], rdata_q[31:24]};
          default: fmt_data = data_rdata_i;
        endcase
      end
    endcase
  end

  always_comb begin
    resp_valid_d = complete;
    resp_err_d   = complete & final_err;
    rf_we_d      = complete & ~we_q & ~final_err;
    rf_wdata_d   = rf_wdata_q;
    if (complete) begin
      rf_wdata_d = rf_we_d ? fmt_data : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      type_q       <= 2'b00;
      sign_ext_q   <= 1'b0;
      offset_q     <= 2'd0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_wdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      type_q       <= type_d;
      sign_ext_q   <= sign_ext_d;
      offset_q     <= offset_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rf_we_q      <= rf_we_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign rf_wdata_lsu_o   = rf_wdata_q;
  assign rf_we_lsu_o      = rf_we_q;
  assign lsu_resp_valid_o = resp_valid_q;
  assign lsu_resp_err_o   = resp_err_q;

  a_we_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    !lsu_resp_valid_o |-> !rf_we_lsu_o);

endmodule

// File: tb/tb_cve2_load_store_resp.sv
// Bench for cve2_load_store_resp: directed scenarios plus random accesses,
// checked every cycle against a byte-window model of the response merge.
module tb_cve2_load_store_resp;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  type_i;
  logic        sign_ext_i;
  logic [1:0]  addr_offset_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;
  logic        busy_o;
  logic [31:0] rf_wdata_lsu_o;
  logic        rf_we_lsu_o;
  logic        lsu_resp_valid_o;
  logic        lsu_resp_err_o;

  cve2_load_store_resp dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .we_i             (we_i),
    .type_i           (type_i),
    .sign_ext_i       (sign_ext_i),
    .addr_offset_i    (addr_offset_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .busy_o           (busy_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_err_o   (lsu_resp_err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard: {err, rf_we, wdata}
  logic [33:0] exp_q[$];
  logic        exp_busy = 1'b0;
  logic [31:0] exp_hold = 32'h0;
  logic        chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_split(input logic [1:0] typ, input logic [1:0] off);
    return ((typ == 2'b00 || typ == 2'b11) && off != 2'd0) || (typ == 2'b01 && off == 2'd3);
  endfunction

  // Access bytes are a window into the little-endian pair {second, first}.
  function automatic logic [31:0] model_fmt(input logic [1:0] typ, input logic sx,
                                            input logic [1:0] off, input logic [31:0] first,
                                            input logic [31:0] last, input logic split);
    logic [63:0] win;
    logic [31:0] v, mask;
    int nbytes;
    win = split ? {last, first} : {32'h0, last};
    win = win >> (8 * off);
    nbytes = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
    v = win[31:0];
    if (nbytes < 4) begin
      mask = (32'h1 << (8 * nbytes)) - 32'h1;
      v = v & mask;
      if (sx && v[8 * nbytes - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  // compare process
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("busy", {31'h0, busy_o}, {31'h0, exp_busy});
      if (exp_q.size() > 0) begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("resp_valid", {31'h0, lsu_resp_valid_o}, 32'h1);
        check("resp_err", {31'h0, lsu_resp_err_o}, {31'h0, e[33]});
        check("rf_we", {31'h0, rf_we_lsu_o}, {31'h0, e[32]});
        check("rf_wdata", rf_wdata_lsu_o, e[31:0]);
        exp_hold = e[31:0];
      end else begin
        check("idle_valid", {31'h0, lsu_resp_valid_o}, 32'h0);
        check("idle_err", {31'h0, lsu_resp_err_o}, 32'h0);
        check("idle_we", {31'h0, rf_we_lsu_o}, 32'h0);
        check("hold_wdata", rf_wdata_lsu_o, exp_hold);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Idle cycles while an access is outstanding, with ignored req_i noise.
  task automatic gap_cycles(input int n, input logic noise);
    for (int i = 0; i < n; i++) begin
      req_i         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      we_i          = 1'($urandom_range(0, 1));
      type_i        = 2'($urandom_range(0, 3));
      addr_offset_i = 2'($urandom_range(0, 3));
      sign_ext_i    = 1'($urandom_range(0, 1));
      step();
    end
    req_i = 1'b0;
  endtask

  // Full access; returns right after the final response is sampled, so the
  // caller may issue the next req_i back-to-back with the output pulse.
  task automatic do_access(input logic we, input logic [1:0] typ, input logic sx,
                           input logic [1:0] off, input logic [31:0] d0, input logic e0,
                           input logic [31:0] d1, input logic e1, input int gap,
                           input logic coincident, input logic noise);
    logic split, err, rfwe;
    logic [31:0] v;
    split = is_split(typ, off);
    req_i = 1'b1; we_i = we; type_i = typ; sign_ext_i = sx; addr_offset_i = off;
    data_rvalid_i = coincident;
    data_rdata_i  = 32'hDEAD_BEEF;
    data_err_i    = coincident;
    step();
    exp_busy = 1'b1;
    req_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    gap_cycles(gap, noise);
    data_rvalid_i = 1'b1; data_rdata_i = d0; data_err_i = e0;
    step();
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
    if (split) begin
      gap_cycles(gap, noise);
      data_rvalid_i = 1'b1; data_rdata_i = d1; data_err_i = e1;
      step();
      data_rvalid_i = 1'b0; data_err_i = 1'b0;
    end
    err  = split ? (e0 | e1) : e0;
    rfwe = !we && !err;
    v    = split ? model_fmt(typ, sx, off, d0, d1, 1'b1) : model_fmt(typ, sx, off, 32'h0, d0, 1'b0);
    exp_q.push_back({err, rfwe, rfwe ? v : 32'h0});
    exp_busy = 1'b0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    req_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    step();
    rst_i = 1'b0;
    exp_q.delete();
    exp_busy = 1'b0;
    exp_hold = 32'h0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; type_i = 2'b00; sign_ext_i = 1'b0;
    addr_offset_i = 2'd0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0; data_err_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    chk_en = 1'b1;

    // Hand-computed pins of the model.
    check("lit_byte_sx", model_fmt(2'b10, 1'b1, 2'd1, 32'h0, 32'h0000_8000, 1'b0), 32'hFFFF_FF80);
    check("lit_word_split", model_fmt(2'b00, 1'b0, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 1'b1), 32'h3344_AABB);
    check("lit_half_split", model_fmt(2'b01, 1'b0, 2'd3, 32'hF000_0000, 32'h0000_00AB, 1'b1), 32'h0000_ABF0);
    check("lit_half_sx", model_fmt(2'b01, 1'b1, 2'd2, 32'h0, 32'h8001_0000, 1'b0), 32'hFFFF_8001);

    // Signed byte load, offset 1.
    do_access(1'b0, 2'b10, 1'b1, 2'd1, 32'h0000_8000, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("dir_byte_wdata", rf_wdata_lsu_o, 32'hFFFF_FF80);
    check("dir_byte_we", {31'h0, rf_we_lsu_o}, 32'h1);
    step();

    // Split word load, offset 2, three idle cycles between responses.
    do_access(1'b0, 2'b00, 1'b0, 2'd2, 32'hAABB_CCDD, 1'b0, 32'h1122_3344, 1'b0, 3, 1'b0, 1'b0);
    @(negedge clk_i);
    check("dir_word_wdata", rf_wdata_lsu_o, 32'h3344_AABB);
    step();

    // Unsigned half load, offset 3.
    do_access(1'b0, 2'b01, 1'b0, 2'd3, 32'hF000_0000, 1'b0, 32'h0000_00AB, 1'b0, 1, 1'b0, 1'b0);
    @(negedge clk_i);
    check("dir_half_wdata", rf_wdata_lsu_o, 32'h0000_ABF0);
    step();

    // Split word load with an error on the first response only.
    do_access(1'b0, 2'b00, 1'b0, 2'd1, 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 1'b0, 2, 1'b0, 1'b0);
    @(negedge clk_i);
    check("dir_err_flag", {31'h0, lsu_resp_err_o}, 32'h1);
    check("dir_err_wdata", rf_wdata_lsu_o, 32'h0);
    step();

    // Aligned store, then a back-to-back load with a coincident, unconsumed rvalid.
    do_access(1'b1, 2'b00, 1'b0, 2'd0, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 1, 1'b0, 1'b0);
    do_access(1'b0, 2'b00, 1'b0, 2'd0, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 2, 1'b1, 1'b0);
    @(negedge clk_i);
    check("dir_b2b_wdata", rf_wdata_lsu_o, 32'hCAFE_F00D);
    step();

    // Reset while waiting for the second half, then a stray response.
    req_i = 1'b1; we_i = 1'b0; type_i = 2'b00; sign_ext_i = 1'b0; addr_offset_i = 2'd3;
    step();
    exp_busy = 1'b1;
    req_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD_0BAD; data_err_i = 1'b0;
    step();
    apply_reset();
    @(negedge clk_i);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_wdata", rf_wdata_lsu_o, 32'h0);
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF; data_err_i = 1'b1;
    step();
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
    step();
    step();

    // Random accesses.
    for (int n = 0; n < 200; n++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0),
                $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0), 1'b1);
      if ($urandom_range(0, 2) == 0) gap_cycles($urandom_range(1, 3), 1'b0);
      if ($urandom_range(0, 40) == 0) begin
        step();
        apply_reset();
      end
    end
    step();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
